lock_controller: RTL and testbench

//  Combination-lock sequencer directly downstream of the keypad digit accumulator.
//  - Consumes the 32-bit decimal entry value and an ENTER button.
//  - Compares the entry against a stored code and drives the accumulator's enable to clear it.
//  - Produces unlocked / lockout outputs, with a retry limit and a timed lockout.

---
 rtl/lock_pkg.sv | 21 ++
 rtl/lock_timer.sv | 25 ++
 rtl/lock_controller.sv | 154 +++++++++++++++
 tb/tb_lock_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and sizing helpers for the combination-lock sequencer.
package lock_pkg;

  localparam int FAIL_W = 3;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Wide enough to hold the larger of the two timer loads (max - 1).
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by the OPEN and LOCKOUT states; parks at zero rather than wrapping.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         hwclk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge hwclk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Combination-lock sequencer behind the keypad accumulator.
// Define LOCK_PROGRAM_EN to allow re-programming the code while unlocked.
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [31:0] CODE_DEFAULT   = 32'd1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 24000000,
  parameter int          LOCKOUT_CYCLES = 120000000
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic [31:0]       typed,
  input  logic              enter,
  input  logic              lock_req,
  output logic              entry_enable,
  output logic              unlocked,
  output logic              lockout,
  output logic [FAIL_W-1:0] fail_count,
  output logic [2:0]        state_dbg
);

  localparam int TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);

  state_t        state;
  logic          enter_q;
  logic          lock_q;
  logic          enter_rise;
  logic          lock_rise;
  logic [31:0]   code_reg;
  logic          code_match;
  logic          last_try;
  logic          prog_load;
  logic          open_enable;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_zero;

  assign enter_rise = enter & ~enter_q;
  assign lock_rise  = lock_req & ~lock_q;
  // An empty entry never matches, even if the stored code were somehow zero.
  assign code_match = (typed == code_reg) && (typed != 32'd0);
  assign last_try   = (int'(fail_count) + 1) == MAX_TRIES;

`ifdef LOCK_PROGRAM_EN
  logic [31:0] code_q;
  assign code_reg    = code_q;
  assign open_enable = 1'b1;
  // Re-lock wins over programming when both edges land together.
  assign prog_load   = (state == ST_OPEN) && enter_rise && (typed != 32'd0) && !lock_rise;

  always_ff @(posedge hwclk) begin
    if (reset)
      code_q <= CODE_DEFAULT;
    else if (prog_load)
      code_q <= typed;
  end
`else
  assign code_reg    = CODE_DEFAULT;
  assign open_enable = 1'b0;
  assign prog_load   = 1'b0;
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = UNLOCK_LOAD;
    if (state == ST_CHECK) begin
      timer_load  = code_match || last_try;
      timer_value = code_match ? UNLOCK_LOAD : LOCKOUT_LOAD;
    end else if (prog_load) begin
      timer_load  = 1'b1;
    end
  end

  lock_timer #(.W(TW)) u_timer (
    .hwclk      (hwclk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      state        <= ST_CLEAR;
      enter_q      <= 1'b0;
      lock_q       <= 1'b0;
      entry_enable <= 1'b0;
      unlocked     <= 1'b0;
      lockout      <= 1'b0;
      fail_count   <= '0;
    end else begin
      enter_q <= enter;
      lock_q  <= lock_req;
      unique case (state)
        ST_CLEAR: begin
          state        <= ST_ENTRY;
          entry_enable <= 1'b1;
        end
        ST_ENTRY: begin
          if (enter_rise)
            state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (code_match) begin
            state        <= ST_OPEN;
            unlocked     <= 1'b1;
            fail_count   <= '0;
            entry_enable <= open_enable;
          end else if (last_try) begin
            state        <= ST_LOCKOUT;
            lockout      <= 1'b1;
            fail_count   <= FAIL_W'(MAX_TRIES);
            entry_enable <= 1'b0;
          end else begin
            state        <= ST_CLEAR;
            fail_count   <= fail_count + 1'b1;
            entry_enable <= 1'b0;
          end
        end
        ST_OPEN: begin
          if (lock_rise || (timer_zero && !prog_load)) begin
            state        <= ST_CLEAR;
            unlocked     <= 1'b0;
            entry_enable <= 1'b0;
          end else begin
            // A freshly programmed code clears the accumulator for one cycle.
            entry_enable <= open_enable && !prog_load;
          end
        end
        ST_LOCKOUT: begin
          if (timer_zero) begin
            state      <= ST_CLEAR;
            lockout    <= 1'b0;
            fail_count <= '0;
          end
        end
        default: begin
          state        <= ST_CLEAR;
          entry_enable <= 1'b0;
          unlocked     <= 1'b0;
          lockout      <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller with small timer parameters.
module tb_lock_controller;

  localparam int UNLOCK  = 8;
  localparam int LOCKOUT = 16;
`ifdef LOCK_PROGRAM_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic        hwclk;
  logic        reset;
  logic [31:0] typed;
  logic        enter;
  logic        lock_req;
  logic        entry_enable;
  logic        unlocked;
  logic        lockout;
  logic [2:0]  fail_count;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  lock_controller #(
    .CODE_DEFAULT   (32'd1234),
    .MAX_TRIES      (3),
    .UNLOCK_CYCLES  (UNLOCK),
    .LOCKOUT_CYCLES (LOCKOUT)
  ) dut (
    .hwclk        (hwclk),
    .reset        (reset),
    .typed        (typed),
    .enter        (enter),
    .lock_req     (lock_req),
    .entry_enable (entry_enable),
    .unlocked     (unlocked),
    .lockout      (lockout),
    .fail_count   (fail_count),
    .state_dbg    (state_dbg)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  task automatic step(input int n);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive an entry from ENTRY; returns sampled just after CHECK resolves.
  task automatic attempt(input logic [31:0] value, input bit hold);
    typed = value;
    enter = 1'b1;
    step(2);
    if (!hold) enter = 1'b0;
  endtask

  task automatic count_unlocked(output int n);
    n = 0;
    while (unlocked === 1'b1 && n < 64) begin
      n++;
      step(1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
    check({tag, "_ee"}, 32'(entry_enable), 32'd0);
    check({tag, "_unl"}, 32'(unlocked), 32'd0);
    check({tag, "_lo"}, 32'(lockout), 32'd0);
    check({tag, "_fail"}, 32'(fail_count), 32'd0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    typed    = 32'd0;
    enter    = 1'b0;
    lock_req = 1'b0;
    step(2);
    check_reset_values("reset");

    // 1: correct code
    reset = 1'b0;
    step(1);
    check("clear_to_entry", 32'(state_dbg), 32'd1);
    check("entry_ee", 32'(entry_enable), 32'd1);
    typed = 32'd1234;
    enter = 1'b1;
    step(1);
    check("check_state", 32'(state_dbg), 32'd2);
    check("check_not_open", 32'(unlocked), 32'd0);
    step(1);
    enter = 1'b0;
    check("open_state", 32'(state_dbg), 32'd3);
    check("open_fail0", 32'(fail_count), 32'd0);
    check("open_ee", 32'(entry_enable), 32'(PROG));
    count_unlocked(n);
    check("unlock_len", 32'(n), 32'(UNLOCK));
    check("open_exit_state", 32'(state_dbg), 32'd0);
    check("open_exit_ee", 32'(entry_enable), 32'd0);
    step(1);
    check("reentry_ee", 32'(entry_enable), 32'd1);

    // 2: wrong code
    attempt(32'd1235, 1'b0);
    check("wrong_unl", 32'(unlocked), 32'd0);
    check("wrong_fail", 32'(fail_count), 32'd1);
    check("wrong_ee_low", 32'(entry_enable), 32'd0);
    check("wrong_state", 32'(state_dbg), 32'd0);
    step(1);
    check("wrong_ee_back", 32'(entry_enable), 32'd1);
    check("wrong_entry", 32'(state_dbg), 32'd1);

    // 3: lockout after three consecutive failures
    attempt(32'd1, 1'b0);
    check("fail2", 32'(fail_count), 32'd2);
    step(1);
    attempt(32'd1236, 1'b0);
    check("lockout_on", 32'(lockout), 32'd1);
    check("lockout_fail", 32'(fail_count), 32'd3);
    check("lockout_ee", 32'(entry_enable), 32'd0);
    check("lockout_state", 32'(state_dbg), 32'd4);
    typed = 32'd1234;
    n = 0;
    while (lockout === 1'b1 && n < 64) begin
      n++;
      enter    = ~enter;
      lock_req = ~lock_req;
      step(1);
    end
    enter    = 1'b0;
    lock_req = 1'b0;
    check("lockout_len", 32'(n), 32'(LOCKOUT));
    check("lockout_unl", 32'(unlocked), 32'd0);
    check("lockout_fail_clr", 32'(fail_count), 32'd0);
    step(1);
    check("lockout_entry", 32'(state_dbg), 32'd1);

    // 4: early re-lock, enter held high gives one attempt
    attempt(32'd1234, 1'b1);
    check("relock_open", 32'(unlocked), 32'd1);
    step(2);
    check("relock_still_open", 32'(unlocked), 32'd1);
    lock_req = 1'b1;
    step(1);
    check("relock_unl", 32'(unlocked), 32'd0);
    check("relock_state", 32'(state_dbg), 32'd0);
    step(4);
    check("held_entry", 32'(state_dbg), 32'd1);
    check("held_fail", 32'(fail_count), 32'd0);
    enter    = 1'b0;
    lock_req = 1'b0;
    step(1);

    // 5: reset during LOCKOUT, then during OPEN
    attempt(32'd11, 1'b0);
    step(1);
    attempt(32'd22, 1'b0);
    step(1);
    attempt(32'd33, 1'b0);
    check("rst_lo_pre", 32'(lockout), 32'd1);
    step(3);
    reset = 1'b1;
    step(1);
    check_reset_values("rst_lo");
    reset = 1'b0;
    step(1);
    attempt(32'd1234, 1'b0);
    check("rst_open_pre", 32'(unlocked), 32'd1);
    step(1);
    reset = 1'b1;
    step(1);
    check_reset_values("rst_open");
    reset = 1'b0;
    step(1);

    // 6: programming while OPEN (timer restart and new code only with the feature)
    attempt(32'd1234, 1'b0);
    check("prog_open", 32'(unlocked), 32'd1);
    step(2);
    typed = 32'd5566;
    enter = 1'b1;
    step(1);
    check("prog_state", 32'(state_dbg), 32'd3);
    check("prog_ee", 32'(entry_enable), 32'd0);
    enter = 1'b0;
    step(1);
    check("prog_ee_back", 32'(entry_enable), 32'(PROG));
    count_unlocked(n);
    check("prog_remaining", 32'(n), PROG ? 32'd7 : 32'd4);
    step(1);
    attempt(32'd5566, 1'b0);
    check("new_code_unl", 32'(unlocked), 32'(PROG));
    check("new_code_fail", 32'(fail_count), PROG ? 32'd0 : 32'd1);
    lock_req = 1'b1;
    step(1);
    lock_req = 1'b0;
    step(1);
    check("back_to_entry", 32'(state_dbg), 32'd1);
    attempt(32'd1234, 1'b0);
    check("old_code_unl", 32'(unlocked), 32'(!PROG));
    check("old_code_fail", 32'(fail_count), PROG ? 32'd1 : 32'd0);

    // Empty entry counts as a failure
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    attempt(32'd0, 1'b0);
    check("empty_unl", 32'(unlocked), 32'd0);
    check("empty_fail", 32'(fail_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
